// File: rtl/shadow_chain_rx.sv
// ============================================================================
// Module   : shadow_chain_rx
// Brief    : Receive end of a shadow capture dump chain. Optional counters are
//            enabled by SHADOW_RX_STATS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module shadow_chain_rx #(
  parameter int DFF_BITS    = 23,
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 9
) (
  input  logic                sh_clk,
  input  logic                sh_rst,
  input  logic                start,
  output logic                busy,
  output logic                dump_en,
  input  logic                ch_in,
  input  logic                ch_in_vld,
  input  logic                ch_in_done,
  output logic [DFF_BITS-1:0] frame_data,
  output logic                frame_vld,
  input  logic                frame_rdy,
  output logic                err_len,
`ifdef SHADOW_RX_STATS_EN
  output logic                err_timeout,
  output logic [15:0]         frame_cnt,
  output logic [15:0]         err_cnt
`else
  output logic                err_timeout
`endif
);

  localparam int c_bc_w = $clog2(DFF_BITS + 2);
  localparam logic [c_bc_w-1:0] c_bits    = c_bc_w'(DFF_BITS);
  localparam logic [c_bc_w-1:0] c_sat     = c_bc_w'(DFF_BITS + 1);
  localparam logic [CNT_W-1:0]  c_timeout = CNT_W'(TIMEOUT_CYC);
  localparam bit                c_to_en   = (TIMEOUT_CYC != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_SHIFT = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [DFF_BITS-1:0] r_sr;
  logic [c_bc_w-1:0]   r_bit_cnt;
  logic [c_bc_w-1:0]   w_cnt_vld;
  logic [c_bc_w-1:0]   w_cnt_final;
  logic [CNT_W-1:0]    r_idle;
  logic [CNT_W-1:0]    w_idle_inc;
  logic                w_timeout;
  logic                w_accept;
  logic                w_set_len;
  logic                w_set_to;
  logic                w_handshake;
  logic                r_err_len;
  logic                r_err_to;

  // A bit arriving together with done is counted before the length check.
  assign w_cnt_vld   = (r_bit_cnt == c_sat) ? r_bit_cnt : r_bit_cnt + 1'b1;
  assign w_cnt_final = ch_in_vld ? w_cnt_vld : r_bit_cnt;
  assign w_idle_inc  = r_idle + 1'b1;
  assign w_timeout   = c_to_en && !ch_in_vld && (w_idle_inc == c_timeout);

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_set_len    = 1'b0;
    w_set_to     = 1'b0;
    w_handshake  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_REQ;
          w_accept     = 1'b1;
        end
      end
      S_REQ: begin
        w_state_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (ch_in_done) begin
          if (w_cnt_final == c_bits) begin
            w_state_next = S_HOLD;
          end else begin
            w_state_next = S_IDLE;
            w_set_len    = 1'b1;
          end
        end else if (w_timeout) begin
          w_state_next = S_IDLE;
          w_set_to     = 1'b1;
        end
      end
      S_HOLD: begin
        if (frame_rdy) begin
          w_state_next = S_IDLE;
          w_handshake  = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sh_clk) begin
    if (sh_rst) begin
      r_state   <= S_IDLE;
      r_sr      <= '0;
      r_bit_cnt <= '0;
      r_idle    <= '0;
      r_err_len <= 1'b0;
      r_err_to  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_bit_cnt <= '0;
        r_idle    <= '0;
        r_err_len <= 1'b0;
        r_err_to  <= 1'b0;
      end
      if (r_state == S_SHIFT) begin
        if (ch_in_vld) begin
          r_sr      <= {ch_in, r_sr[DFF_BITS-1:1]};
          r_bit_cnt <= w_cnt_vld;
          r_idle    <= '0;
        end else begin
          r_idle <= w_idle_inc;
        end
      end
      if (w_set_len) begin
        r_err_len <= 1'b1;
      end
      if (w_set_to) begin
        r_err_to <= 1'b1;
      end
    end
  end

`ifdef SHADOW_RX_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_err_cnt;

  always_ff @(posedge sh_clk) begin
    if (sh_rst) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (w_handshake) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      if (w_set_len || w_set_to) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;
`endif

  assign busy        = (r_state != S_IDLE);
  assign dump_en     = (r_state == S_REQ);
  assign frame_vld   = (r_state == S_HOLD);
  assign frame_data  = r_sr;
  assign err_len     = r_err_len;
  assign err_timeout = r_err_to;

endmodule

`default_nettype wire

// File: tb/tb_shadow_chain_rx.sv
// ============================================================================
// Module   : tb_shadow_chain_rx
// Brief    : Directed self-checking bench for shadow_chain_rx (TIMEOUT_CYC=16).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_shadow_chain_rx;

  localparam int c_bits = 23;

  logic              sh_clk = 1'b0;
  logic              sh_rst;
  logic              start;
  logic              busy;
  logic              dump_en;
  logic              ch_in;
  logic              ch_in_vld;
  logic              ch_in_done;
  logic [c_bits-1:0] frame_data;
  logic              frame_vld;
  logic              frame_rdy;
  logic              err_len;
  logic              err_timeout;
`ifdef SHADOW_RX_STATS_EN
  logic [15:0]       frame_cnt;
  logic [15:0]       err_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  shadow_chain_rx #(
    .DFF_BITS   (c_bits),
    .TIMEOUT_CYC(16),
    .CNT_W      (9)
  ) dut (
    .sh_clk     (sh_clk),
    .sh_rst     (sh_rst),
    .start      (start),
    .busy       (busy),
    .dump_en    (dump_en),
    .ch_in      (ch_in),
    .ch_in_vld  (ch_in_vld),
    .ch_in_done (ch_in_done),
    .frame_data (frame_data),
    .frame_vld  (frame_vld),
    .frame_rdy  (frame_rdy),
    .err_len    (err_len),
`ifdef SHADOW_RX_STATS_EN
    .err_timeout(err_timeout),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt)
`else
    .err_timeout(err_timeout)
`endif
  );

  always #5 sh_clk = ~sh_clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic drive_bits(input logic [31:0] v, input int n, input logic done_last);
    for (int i = 0; i < n; i++) begin
      ch_in      = v[i];
      ch_in_vld  = 1'b1;
      ch_in_done = done_last && (i == n - 1);
      @(negedge sh_clk);
    end
    ch_in      = 1'b0;
    ch_in_vld  = 1'b0;
    ch_in_done = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge sh_clk);
  endtask

  task automatic do_start;
    start = 1'b1;
    @(negedge sh_clk);
    start = 1'b0;
    n_checks++;
    if (dump_en !== 1'b1 || busy !== 1'b1 || err_len !== 1'b0 || err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL start_req: dump_en=%b busy=%b err_len=%b err_to=%b, expected 1 1 0 0",
               dump_en, busy, err_len, err_timeout);
    end
    @(negedge sh_clk);
    n_checks++;
    if (dump_en !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL dump_en_pulse: dump_en=%b busy=%b, expected 0 1", dump_en, busy);
    end
  endtask

  task automatic release_frame;
    frame_rdy = 1'b1;
    @(negedge sh_clk);
    frame_rdy = 1'b0;
    n_checks++;
    if (frame_vld !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL release: frame_vld=%b busy=%b, expected 0 0", frame_vld, busy);
    end
  endtask

  task automatic test_reset;
    sh_rst = 1'b1; start = 1'b0; ch_in = 1'b0; ch_in_vld = 1'b0;
    ch_in_done = 1'b0; frame_rdy = 1'b0;
    idle_cycles(3);
    sh_rst = 1'b0;
    n_checks++;
    if ({busy, dump_en, frame_vld, err_len, err_timeout} !== 5'b0 || frame_data !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy/dump_en/vld/len/to=%b data=%h, expected 00000 0",
               {busy, dump_en, frame_vld, err_len, err_timeout}, frame_data);
    end
  endtask

  task automatic test_normal;
    do_start();
    drive_bits(32'h0012_3456, c_bits, 1'b1);
    n_checks++;
    if (frame_vld !== 1'b1 || frame_data !== 23'h123456 || err_len !== 1'b0 || err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL normal_frame: vld=%b data=%h len=%b to=%b, expected 1 123456 0 0",
               frame_vld, frame_data, err_len, err_timeout);
    end
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      @(negedge sh_clk);
      n_checks++;
      if (frame_vld !== 1'b1 || frame_data !== 23'h123456 || dump_en !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_%0d: vld=%b data=%h dump_en=%b, expected 1 123456 0",
                 i, frame_vld, frame_data, dump_en);
      end
    end
    start = 1'b0;
    release_frame();
    @(negedge sh_clk);
    n_checks++;
    if (dump_en !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_not_queued: dump_en=%b busy=%b, expected 0 0", dump_en, busy);
    end
  endtask

  task automatic test_short_long;
    do_start();
    drive_bits(32'h0000_0ABC, 22, 1'b1);
    n_checks++;
    if (err_len !== 1'b1 || frame_vld !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL short_len: err_len=%b vld=%b busy=%b, expected 1 0 0", err_len, frame_vld, busy);
    end
    do_start();
    drive_bits(32'h01FF_FFFF, 25, 1'b1);
    n_checks++;
    if (err_len !== 1'b1 || frame_vld !== 1'b0 || busy !== 1'b0 || err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL long_len: err_len=%b vld=%b busy=%b to=%b, expected 1 0 0 0",
               err_len, frame_vld, busy, err_timeout);
    end
  endtask

  task automatic test_timeout;
    do_start();
    drive_bits(32'h0000_02AA, 10, 1'b0);
    idle_cycles(15);
    n_checks++;
    if (busy !== 1'b1 || err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: busy=%b err_to=%b, expected 1 0", busy, err_timeout);
    end
    idle_cycles(1);
    n_checks++;
    if (busy !== 1'b0 || err_timeout !== 1'b1 || err_len !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_hit: busy=%b err_to=%b err_len=%b, expected 0 1 0", busy, err_timeout, err_len);
    end
    // Done without a bit on the 16th idle cycle must still deliver the frame.
    do_start();
    drive_bits(32'h0055_1234, c_bits, 1'b0);
    idle_cycles(15);
    ch_in_done = 1'b1;
    @(negedge sh_clk);
    ch_in_done = 1'b0;
    n_checks++;
    if (frame_vld !== 1'b1 || frame_data !== 23'h551234 || err_timeout !== 1'b0 || err_len !== 1'b0) begin
      n_fail++;
      $display("FAIL done_beats_timeout: vld=%b data=%h to=%b len=%b, expected 1 551234 0 0",
               frame_vld, frame_data, err_timeout, err_len);
    end
    release_frame();
  endtask

  task automatic test_reset_mid_shift;
    do_start();
    drive_bits(32'h0000_0F0F, 12, 1'b0);
    sh_rst = 1'b1;
    @(negedge sh_clk);
    sh_rst = 1'b0;
    n_checks++;
    if ({busy, dump_en, frame_vld, err_len, err_timeout} !== 5'b0 || frame_data !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: busy/dump_en/vld/len/to=%b data=%h, expected 00000 0",
               {busy, dump_en, frame_vld, err_len, err_timeout}, frame_data);
    end
    drive_bits(32'h0000_07FF, 11, 1'b1);
    n_checks++;
    if (busy !== 1'b0 || frame_vld !== 1'b0 || err_len !== 1'b0 || frame_data !== '0) begin
      n_fail++;
      $display("FAIL idle_ignores_chain: busy=%b vld=%b len=%b data=%h, expected 0 0 0 0",
               busy, frame_vld, err_len, frame_data);
    end
    do_start();
    drive_bits(32'h005A_5A5A, c_bits, 1'b1);
    n_checks++;
    if (frame_vld !== 1'b1 || frame_data !== 23'h5A5A5A) begin
      n_fail++;
      $display("FAIL fresh_dump: vld=%b data=%h, expected 1 5a5a5a", frame_vld, frame_data);
    end
    release_frame();
  endtask

`ifdef SHADOW_RX_STATS_EN
  task automatic test_stats;
    for (int k = 0; k < 2; k++) begin
      do_start();
      drive_bits(32'h0001_0000 + k, c_bits, 1'b1);
      release_frame();
    end
    do_start();
    drive_bits(32'h0000_0001, 5, 1'b1);
    n_checks++;
    if (frame_cnt !== 16'd3 || err_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL stats: frame_cnt=%0d err_cnt=%0d, expected 3 1", frame_cnt, err_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_normal();
    test_backpressure();
    test_short_long();
    test_timeout();
    test_reset_mid_shift();
`ifdef SHADOW_RX_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
